// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues stores, drains one per cycle when no load owns the
// memory port, and forwards loads from the youngest exactly-matching queued store.
module mem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    st_valid,
    input  logic [AW-1:0]           st_addr,
    input  logic [DW-1:0]           st_data,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [AW-1:0]           ld_addr,
    output logic [DW-1:0]           ld_data,
    output logic                    ld_hit,
    output logic                    ld_stall,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [$clog2(DEPTH):0]  count,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic            exact, partial;
    logic [DW-1:0]   fwd_data;
    logic [PW-1:0]   idx;
    logic [AW-1:0]   diff;
    logic            load_port, drain, push;

    // Walk entries oldest to youngest so the last exact match is the youngest store.
    always_comb begin
        exact    = 1'b0;
        partial  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        diff     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx  = rd_ptr + PW'(i);
            diff = ld_addr - addr_q[idx];
            if (valid_q[idx]) begin
                if (diff == '0) begin
                    exact    = 1'b1;
                    fwd_data = data_q[idx];
                end else if ((diff < AW'(4)) || (diff > ~AW'(3))) begin
                    partial = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ld_stall   = ld_valid && partial;
        ld_hit     = ld_valid && exact && !partial;
        ld_data    = ld_hit ? fwd_data : mem_rdata;
        load_port  = ld_valid && !partial;
        drain      = !load_port && (count != '0);
        mem_re     = load_port;
        mem_we     = drain;
        mem_addr   = load_port ? ld_addr : addr_q[rd_ptr];
        mem_wdata  = data_q[rd_ptr];
        st_ready   = (count < CW'(DEPTH)) && (state_q == RUN);
        push       = st_valid && st_ready;
        flush_done = (state_q == FLUSH) && (count == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req) state_d = FLUSH;
            FLUSH:   if (count == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (drain) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
                addr_q[wr_ptr]  <= st_addr;
                data_q[wr_ptr]  <= st_data;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(drain);
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios plus random traffic checked against a
// queue-based reference model and a behavioural data memory.
module tb_mem_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        st_valid, ld_valid, flush_req;
    logic [31:0] st_addr, st_data, ld_addr, mem_rdata;
    logic        st_ready, ld_hit, ld_stall, flush_done, mem_we, mem_re;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [2:0]  count;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .ld_stall(ld_stall), .flush_req(flush_req), .flush_done(flush_done), .count(count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_flush;
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    int total = 0;
    int bad   = 0;

    bit          e_st_ready, e_hit, e_stall, e_re, e_we, e_fdone;
    logic [31:0] e_ld_data, e_maddr, e_wdata;
    int          e_count;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
    endfunction

    // Drive one cycle's inputs at the falling edge and derive the expected outputs.
    task automatic apply(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                         input bit lv, input logic [31:0] la, input bit fr);
        logic [31:0] diff;
        logic [31:0] fwd;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; flush_req = fr;
        e_count    = q.size();
        e_st_ready = (q.size() < DEPTH) && !m_flush;
        e_hit = 0; e_stall = 0; fwd = '0;
        foreach (q[i]) begin
            diff = la - q[i].a;
            if (diff == 32'h0) begin
                e_hit = 1; fwd = q[i].d;
            end else if (diff < 32'd4 || diff > 32'hFFFF_FFFC) begin
                e_stall = 1;
            end
        end
        if (e_stall) e_hit = 0;
        e_re      = lv && !e_stall;
        e_we      = !e_re && (q.size() > 0);
        e_maddr   = e_re ? la : (e_we ? q[0].a : 32'h0);
        e_wdata   = e_we ? q[0].d : 32'h0;
        e_ld_data = e_hit ? fwd : ref_rd(la);
        e_fdone   = m_flush && (q.size() == 0);
        #1;
        mem_rdata = phys_rd(mem_addr);
        #1;
    endtask

    task automatic idle();
        apply(0, 32'h0, 32'h0, 0, 32'h0, 0);
    endtask

    // Clock edge: the behavioural memory takes the DUT's write, the model takes its own.
    task automatic advance();
        bit          pushed, w_en;
        logic [31:0] w_a, w_d;
        ent_t        ne;
        pushed = st_valid && e_st_ready;
        ne.a = st_addr; ne.d = st_data;
        w_en = mem_we; w_a = mem_addr; w_d = mem_wdata;
        @(posedge clk);
        if (w_en) phys_mem[w_a] = w_d;
        if (e_we) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (pushed) q.push_back(ne);
        if (!m_flush && flush_req) m_flush = 1;
        else if (m_flush && e_count == 0) m_flush = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        st_valid = 0; ld_valid = 0; flush_req = 0;
        st_addr = '0; st_data = '0; ld_addr = '0; mem_rdata = '0;
        reset_n = 0;
        q.delete(); m_flush = 0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL reset_mem got we=%0b re=%0b exp 0/0", mem_we, mem_re); end
        total++; if (st_ready !== 1'b1 || flush_done !== 1'b0) begin bad++; $display("FAIL reset_ctl got rdy=%0b fd=%0b exp 1/0", st_ready, flush_done); end
        total++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0) begin bad++; $display("FAIL reset_ld got hit=%0b stall=%0b exp 0/0", ld_hit, ld_stall); end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_single_store();
        apply(1, 32'h10, 32'h1122_3344, 0, 32'h0, 0);
        total++; if (st_ready !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL single_push got rdy=%0b we=%0b exp 1/0", st_ready, mem_we); end
        advance();
        idle();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h1122_3344)
            begin bad++; $display("FAIL single_drain got we=%0b a=%h d=%h exp 1/10/11223344", mem_we, mem_addr, mem_wdata); end
        advance();
        idle();
        total++; if (count !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL single_empty got cnt=%0d we=%0b exp 0/0", count, mem_we); end
        advance();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            apply(1, 32'(i * 4), $urandom, 1, 32'h40, 0);
            total++; if (st_ready !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0)
                begin bad++; $display("FAIL fill_push%0d got rdy=%0b re=%0b we=%0b exp 1/1/0", i, st_ready, mem_re, mem_we); end
            advance();
        end
        apply(1, 32'h20, $urandom, 1, 32'h40, 0);
        total++; if (count !== 3'd4 || st_ready !== 1'b0) begin bad++; $display("FAIL fill_full got cnt=%0d rdy=%0b exp 4/0", count, st_ready); end
        total++; if (ld_hit !== 1'b0 || ld_data !== e_ld_data) begin bad++; $display("FAIL fill_ldmiss got hit=%0b d=%h exp 0/%h", ld_hit, ld_data, e_ld_data); end
        advance();
        for (int i = 0; i < 4; i++) begin
            idle();
            total++; if (mem_we !== 1'b1 || mem_addr !== 32'(i * 4) || mem_wdata !== e_wdata)
                begin bad++; $display("FAIL fill_drain%0d got we=%0b a=%h d=%h exp 1/%h/%h", i, mem_we, mem_addr, mem_wdata, 32'(i * 4), e_wdata); end
            advance();
        end
        idle();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL fill_empty got cnt=%0d exp 0", count); end
        advance();
    endtask

    task automatic test_forward_youngest();
        apply(1, 32'h10, 32'hAAAA_0001, 0, 32'h0, 0);
        advance();
        apply(1, 32'h10, 32'hBBBB_0002, 1, 32'h10, 0);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'hAAAA_0001) begin bad++; $display("FAIL fwd_old got hit=%0b d=%h exp 1/aaaa0001", ld_hit, ld_data); end
        advance();
        apply(0, 32'h0, 32'h0, 1, 32'h10, 0);
        total++; if (ld_hit !== 1'b1 || ld_data !== 32'hBBBB_0002) begin bad++; $display("FAIL fwd_young got hit=%0b d=%h exp 1/bbbb0002", ld_hit, ld_data); end
        total++; if (mem_we !== 1'b0 || count !== 3'd2) begin bad++; $display("FAIL fwd_hold got we=%0b cnt=%0d exp 0/2", mem_we, count); end
        advance();
        idle(); advance();
        idle(); advance();
        apply(0, 32'h0, 32'h0, 1, 32'h10, 0);
        total++; if (ld_hit !== 1'b0 || ld_data !== 32'hBBBB_0002) begin bad++; $display("FAIL fwd_mem got hit=%0b d=%h exp 0/bbbb0002", ld_hit, ld_data); end
        advance();
    endtask

    task automatic test_overlap_stall();
        apply(1, 32'h20, 32'hC0DE_0020, 1, 32'h40, 0); advance();
        apply(1, 32'h12, 32'hC0DE_0012, 1, 32'h40, 0); advance();
        for (int i = 0; i < 2; i++) begin
            apply(0, 32'h0, 32'h0, 1, 32'h10, 0);
            total++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin bad++; $display("FAIL ovl_stall%0d got st=%0b hit=%0b exp 1/0", i, ld_stall, ld_hit); end
            total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== e_maddr)
                begin bad++; $display("FAIL ovl_drain%0d got we=%0b re=%0b a=%h exp 1/0/%h", i, mem_we, mem_re, mem_addr, e_maddr); end
            advance();
        end
        apply(0, 32'h0, 32'h0, 1, 32'h10, 0);
        total++; if (ld_stall !== 1'b0 || ld_hit !== 1'b0 || ld_data !== e_ld_data || mem_re !== 1'b1)
            begin bad++; $display("FAIL ovl_release got st=%0b hit=%0b d=%h re=%0b exp 0/0/%h/1", ld_stall, ld_hit, ld_data, mem_re, e_ld_data); end
        advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h300 + 32'(i * 4), $urandom, 1, 32'h40, 0);
            advance();
        end
        apply(0, 32'h0, 32'h0, 0, 32'h0, 1);
        total++; if (st_ready !== 1'b1 || flush_done !== 1'b0) begin bad++; $display("FAIL flush_req got rdy=%0b fd=%0b exp 1/0", st_ready, flush_done); end
        advance();
        for (int k = 1; k <= 4; k++) begin
            apply(k < 4, 32'h400, $urandom, 0, 32'h0, 0);
            total++; if (flush_done !== (k == 3)) begin bad++; $display("FAIL flush_done_k%0d got=%0b exp=%0b", k, flush_done, (k == 3)); end
            total++; if (st_ready !== (k == 4)) begin bad++; $display("FAIL flush_rdy_k%0d got=%0b exp=%0b", k, st_ready, (k == 4)); end
            advance();
        end
        idle();
        total++; if (count !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL flush_blocked got cnt=%0d we=%0b exp 0/0", count, mem_we); end
        apply(0, 32'h0, 32'h0, 0, 32'h0, 1);
        total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL flush_empty0 got=%0b exp=0", flush_done); end
        advance();
        idle();
        total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_empty1 got=%0b exp=1", flush_done); end
        advance();
        idle();
        total++; if (flush_done !== 1'b0 || st_ready !== 1'b1) begin bad++; $display("FAIL flush_empty2 got fd=%0b rdy=%0b exp 0/1", flush_done, st_ready); end
        advance();
    endtask

    task automatic test_reset_mid_drain();
        apply(1, 32'h100, 32'hDEAD_0100, 1, 32'h40, 0); advance();
        apply(1, 32'h104, 32'hDEAD_0104, 1, 32'h40, 0); advance();
        idle();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL rmd_first got we=%0b a=%h exp 1/100", mem_we, mem_addr); end
        advance();
        idle();
        #1 reset_n = 0;
        q.delete(); m_flush = 0;
        #1;
        total++; if (count !== 3'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL rmd_async got cnt=%0d we=%0b exp 0/0", count, mem_we); end
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            total++; if (mem_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL rmd_quiet%0d got we=%0b cnt=%0d exp 0/0", i, mem_we, count); end
            advance();
        end
        total++; if (phys_mem.exists(32'h104) != 0) begin bad++; $display("FAIL rmd_lost got written=1 exp written=0"); end
    endtask

    task automatic test_random();
        bit          sv, lv, fr;
        logic [31:0] sa, la;
        int          guard;
        for (int n = 0; n < 400; n++) begin
            sv = ($urandom_range(0, 1) == 1);
            lv = ($urandom_range(0, 2) == 0);
            fr = ($urandom_range(0, 39) == 0);
            sa = 32'($urandom_range(0, 7) * 4);
            la = 32'($urandom_range(0, 9) * 4);
            apply(sv, sa, $urandom, lv, la, fr);
            total++; if (st_ready !== e_st_ready || count !== 3'(e_count))
                begin bad++; $display("FAIL rnd_ctl n=%0d got rdy=%0b cnt=%0d exp %0b/%0d", n, st_ready, count, e_st_ready, e_count); end
            total++; if (mem_we !== e_we || mem_re !== e_re || flush_done !== e_fdone)
                begin bad++; $display("FAIL rnd_port n=%0d got we=%0b re=%0b fd=%0b exp %0b/%0b/%0b", n, mem_we, mem_re, flush_done, e_we, e_re, e_fdone); end
            if (e_we || e_re) begin
                total++; if (mem_addr !== e_maddr) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr, e_maddr); end
            end
            if (e_we) begin
                total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, e_wdata); end
            end
            if (lv) begin
                total++; if (ld_stall !== e_stall || ld_hit !== e_hit)
                    begin bad++; $display("FAIL rnd_ldflags n=%0d got st=%0b hit=%0b exp %0b/%0b", n, ld_stall, ld_hit, e_stall, e_hit); end
                total++; if (ld_data !== e_ld_data) begin bad++; $display("FAIL rnd_lddata n=%0d got=%h exp=%h", n, ld_data, e_ld_data); end
            end
            advance();
        end
        guard = 0;
        while ((q.size() > 0 || m_flush) && guard < 20) begin
            idle(); advance(); guard++;
        end
        idle();
        total++; if (count !== 3'd0 || q.size() != 0) begin bad++; $display("FAIL rnd_drain got cnt=%0d model=%0d exp 0/0", count, q.size()); end
        advance();
        foreach (ref_mem[k]) begin
            total++; if (phys_rd(k) !== ref_mem[k]) begin bad++; $display("FAIL rnd_mem a=%h got=%h exp=%h", k, phys_rd(k), ref_mem[k]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1;
        m_flush = 0;
        test_reset();
        test_single_store();
        test_fill_drain();
        test_forward_youngest();
        test_overlap_stall();
        test_flush();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
